// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i ROM fetch path: cache key layout, cache ops, fetch FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_AW    = XLEN - 2;
    localparam int unsigned INDEX_W    = 6;
    localparam int unsigned TAG_W      = WORD_AW - INDEX_W;

    localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

    // Direct-mapped cache lookup key, taken from the word address
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
    } rv32i_rom_cache_key_s;

    typedef enum logic [1:0] {
        CACHE_NONE  = 2'd0,
        CACHE_LOAD  = 2'd1,
        CACHE_STORE = 2'd2
    } cache_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        FILL    = 2'd2
    } fetch_state_e;

    // Split a word address into {tag, index}
    function automatic rv32i_rom_cache_key_s key_of(input logic [WORD_AW-1:0] waddr);
        return rv32i_rom_cache_key_s'(waddr);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on each event until the counter is full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction-fetch front end: zero-latency hits from rom_cache, ROM refill over req/ack on a miss.
module rom_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_addr,
    output logic                 fetch_ready,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic                 instr_fault,
    input  logic                 flush,
    output rv32i_rom_cache_key_s cache_key,
    output cache_op_e            cache_op,
    output logic [31:0]          cache_wdata,
    input  logic                 cache_hit,
    input  logic [31:0]          cache_rdata,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    fetch_state_e        state_q, state_d;
    logic [WORD_AW-1:0]  addr_q;
    logic [31:0]         data_q;
    logic                drop_q, drop_d;
    logic                latch_addr, latch_data;
    logic                hit_inc, miss_inc;
    logic                fault;

    // Misaligned or outside [ROM_BASE, ROM_BASE+ROM_SIZE); unsigned wrap covers addresses below base
    assign fault = (fetch_addr[1:0] != 2'b00) || ((fetch_addr - ROM_BASE) >= ROM_SIZE);

    assign mem_addr    = {addr_q, 2'b00};
    assign cache_wdata = data_q;

    // State and datapath registers; reset abandons any outstanding ROM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (latch_addr) addr_q <= fetch_addr[31:2];
            if (latch_data) data_q <= mem_rdata;
        end
    end

    // Next state, cache/ROM controls and the same-cycle fetch response
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        latch_addr  = 1'b0;
        latch_data  = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        fetch_ready = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        instr_fault = 1'b0;
        mem_req     = 1'b0;
        cache_op    = CACHE_NONE;
        cache_key   = key_of(addr_q);

        case (state_q)
            IDLE: begin
                cache_key = key_of(fetch_addr[31:2]);
                drop_d    = 1'b0;
                if (fetch_valid && !flush) begin
                    if (fault) begin
                        fetch_ready = 1'b1;
                        instr_valid = 1'b1;
                        instr_fault = 1'b1;
                        instr       = RV32I_NOP;
                    end else begin
                        cache_op = CACHE_LOAD;
                        if (cache_hit) begin
                            fetch_ready = 1'b1;
                            instr_valid = 1'b1;
                            instr       = cache_rdata;
                            hit_inc     = 1'b1;
                        end else begin
                            latch_addr = 1'b1;
                            miss_inc   = 1'b1;
                            state_d    = MEM_REQ;
                        end
                    end
                end
            end
            MEM_REQ: begin
                mem_req = 1'b1;
                if (flush) drop_d = 1'b1;
                if (mem_ack) begin
                    latch_data = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                cache_op = CACHE_STORE;
                state_d  = IDLE;
                drop_d   = 1'b0;
                if (!drop_q && !flush) begin
                    fetch_ready = 1'b1;
                    instr_valid = 1'b1;
                    instr       = data_q;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    sat_counter #(.WIDTH(32)) u_hit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit_inc),
        .count   (hit_count)
    );

    sat_counter #(.WIDTH(32)) u_miss_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_inc),
        .count   (miss_count)
    );

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit with a behavioural rom_cache and ROM bridge.
module tb_rom_fetch_unit;
    import rv32i_pkg::*;

    localparam int unsigned ROM_LAT = 3;  // mem_req cycles up to and including the ack

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 fetch_valid;
    logic [31:0]          fetch_addr;
    logic                 fetch_ready;
    logic                 instr_valid;
    logic [31:0]          instr;
    logic                 instr_fault;
    logic                 flush;
    rv32i_rom_cache_key_s cache_key;
    cache_op_e            cache_op;
    logic [31:0]          cache_wdata;
    logic                 cache_hit;
    logic [31:0]          cache_rdata;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_ack;
    logic [31:0]          mem_rdata;
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_fetch_unit #(
        .ROM_BASE (32'h0000_0000),
        .ROM_SIZE (32'h0001_0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_fault (instr_fault),
        .flush       (flush),
        .cache_key   (cache_key),
        .cache_op    (cache_op),
        .cache_wdata (cache_wdata),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // Direct-mapped cache model: combinational read, write on CACHE_STORE
    logic [63:0]      c_valid = '0;
    logic [TAG_W-1:0] c_tag  [64];
    logic [31:0]      c_data [64];

    assign cache_hit   = c_valid[cache_key.index] && (c_tag[cache_key.index] == cache_key.tag);
    assign cache_rdata = c_data[cache_key.index];

    always @(posedge clk) begin
        if (cache_op == CACHE_STORE) begin
            c_valid[cache_key.index] <= 1'b1;
            c_tag[cache_key.index]   <= cache_key.tag;
            c_data[cache_key.index]  <= cache_wdata;
        end
    end

    // ROM contents: 0x100 holds addi x1,x0,5; elsewhere {addr[15:0], 16'h0093}
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], 16'h0093};
    endfunction

    // ROM bridge model: acks on the ROM_LAT-th cycle of mem_req
    logic        rom_ack = 1'b0;
    logic [31:0] rom_data = '0;
    logic        inj_ack = 1'b0;
    logic [31:0] inj_data = '0;
    int          req_cycles = 0;

    assign mem_ack   = rom_ack | inj_ack;
    assign mem_rdata = inj_ack ? inj_data : rom_data;

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            req_cycles = req_cycles + 1;
            if (req_cycles == ROM_LAT) begin
                rom_ack    = 1'b1;
                rom_data   = rom_word(mem_addr);
                req_cycles = 0;
            end else begin
                rom_ack = 1'b0;
            end
        end else begin
            rom_ack    = 1'b0;
            req_cycles = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction; reports latency in cycles (request cycle = 1)
    task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] ins,
                            output logic flt, output int req_cyc, output int stores);
        lat = 0; ins = '0; flt = 1'b0; req_cyc = 0; stores = 0;
        step();
        fetch_valid = 1'b1;
        fetch_addr  = a;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cyc++;
                check_eq("mem_addr_held", mem_addr, {a[31:2], 2'b00});
            end
            if (cache_op == CACHE_STORE) stores++;
            if (instr_valid) begin
                lat = i;
                ins = instr;
                flt = instr_fault;
                check_eq("ready_with_valid", 32'(fetch_ready), 32'd1);
                break;
            end
            step();
            if (i == 1) fetch_addr = a ^ 32'h0000_0400;  // must be ignored once latched
        end
        if (lat == 0) check_eq("fetch_timeout", 32'd0, 32'd1);
        step();
        fetch_valid = 1'b0;
        fetch_addr  = '0;
    endtask

    int          lat, req_cyc, stores, valids;
    logic [31:0] ins;
    logic        flt;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_cache_op", 32'(cache_op), 32'(CACHE_NONE));
        check_eq("rst_hit_count", hit_count, 32'd0);
        check_eq("rst_miss_count", miss_count, 32'd0);
        step();
        reset_n = 1'b1;

        // Cold miss on 0x100
        do_fetch(32'h0000_0100, lat, ins, flt, req_cyc, stores);
        check_eq("cold_latency", 32'(lat), 32'd5);
        check_eq("cold_instr", ins, 32'h0050_0093);
        check_eq("cold_fault", 32'(flt), 32'd0);
        check_eq("cold_req_cycles", 32'(req_cyc), 32'd3);
        check_eq("cold_stores", 32'(stores), 32'd1);
        check_eq("cold_miss_count", miss_count, 32'd1);
        check_eq("cold_hit_count", hit_count, 32'd0);

        // Re-fetch hits with zero latency
        do_fetch(32'h0000_0100, lat, ins, flt, req_cyc, stores);
        check_eq("hit_latency", 32'(lat), 32'd1);
        check_eq("hit_instr", ins, 32'h0050_0093);
        check_eq("hit_req_cycles", 32'(req_cyc), 32'd0);
        check_eq("hit_hit_count", hit_count, 32'd1);

        // Conflict: 0x200 shares index 0 with 0x100
        do_fetch(32'h0000_0200, lat, ins, flt, req_cyc, stores);
        check_eq("conf_latency", 32'(lat), 32'd5);
        check_eq("conf_instr", ins, 32'h0200_0093);
        do_fetch(32'h0000_0100, lat, ins, flt, req_cyc, stores);
        check_eq("conf_back_latency", 32'(lat), 32'd5);
        check_eq("conf_back_instr", ins, 32'h0050_0093);
        check_eq("conf_miss_count", miss_count, 32'd3);

        // Faults: misaligned and first byte past ROM
        do_fetch(32'h0000_0102, lat, ins, flt, req_cyc, stores);
        check_eq("misal_latency", 32'(lat), 32'd1);
        check_eq("misal_fault", 32'(flt), 32'd1);
        check_eq("misal_instr", ins, 32'h0000_0013);
        check_eq("misal_req", 32'(req_cyc), 32'd0);
        do_fetch(32'h0001_0000, lat, ins, flt, req_cyc, stores);
        check_eq("oor_fault", 32'(flt), 32'd1);
        check_eq("oor_instr", ins, 32'h0000_0013);
        check_eq("oor_req", 32'(req_cyc), 32'd0);
        check_eq("fault_hit_count", hit_count, 32'd1);
        check_eq("fault_miss_count", miss_count, 32'd3);

        // Flush during MEM_REQ: refill completes silently
        step();
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0300;
        @(negedge clk);
        check_eq("fl_miss_ready", 32'(fetch_ready), 32'd0);
        step();
        fetch_valid = 1'b0;
        flush       = 1'b1;
        @(negedge clk);
        check_eq("fl_mem_req", 32'(mem_req), 32'd1);
        req_cyc = 1; stores = 0; valids = 0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req) req_cyc++;
            if (cache_op == CACHE_STORE) stores++;
            if (instr_valid) valids++;
            step();
        end
        check_eq("fl_req_cycles", 32'(req_cyc), 32'd3);
        check_eq("fl_stores", 32'(stores), 32'd1);
        check_eq("fl_valids", 32'(valids), 32'd0);
        check_eq("fl_miss_count", miss_count, 32'd4);
        do_fetch(32'h0000_0300, lat, ins, flt, req_cyc, stores);
        check_eq("fl_refetch_latency", 32'(lat), 32'd1);
        check_eq("fl_refetch_instr", ins, 32'h0300_0093);
        check_eq("fl_hit_count", hit_count, 32'd2);

        // Flush in IDLE suppresses a would-be hit
        step();
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0300;
        flush       = 1'b1;
        @(negedge clk);
        check_eq("idle_flush_valid", 32'(instr_valid), 32'd0);
        check_eq("idle_flush_ready", 32'(fetch_ready), 32'd0);
        step();
        fetch_valid = 1'b0;
        flush       = 1'b0;
        check_eq("idle_flush_hit_count", hit_count, 32'd2);

        // Reset during MEM_REQ, then a late ack
        step();
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0400;
        step();
        fetch_valid = 1'b0;
        @(negedge clk);
        check_eq("rr_mem_req_before", 32'(mem_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("rr_mem_req_async", 32'(mem_req), 32'd0);
        check_eq("rr_miss_count", miss_count, 32'd0);
        check_eq("rr_hit_count", hit_count, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        inj_ack  = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("rr_late_ack_op", 32'(cache_op), 32'(CACHE_NONE));
        check_eq("rr_late_ack_req", 32'(mem_req), 32'd0);
        step();
        inj_ack = 1'b0;
        @(negedge clk);
        check_eq("rr_after_ack_op", 32'(cache_op), 32'(CACHE_NONE));
        check_eq("rr_after_ack_valid", 32'(instr_valid), 32'd0);
        do_fetch(32'h0000_0400, lat, ins, flt, req_cyc, stores);
        check_eq("rr_fetch_latency", 32'(lat), 32'd5);
        check_eq("rr_fetch_instr", ins, 32'h0400_0093);
        check_eq("rr_fetch_miss_count", miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
